// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment scan controller
package seg_pkg;
  typedef enum logic {SCAN_BLANK, SCAN_ON} scan_state_t;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  function automatic int cmax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: digit data in, shared cathode/anode bus out
interface seg_scan_ctrl_if #(parameter int NUM_DIGITS = 3);
  logic [3:0]            digit_i [NUM_DIGITS-1:0];
  logic [NUM_DIGITS-1:0] en_i;
  logic [NUM_DIGITS-1:0] dp_i;
  logic [7:0]            seg_o;
  logic [NUM_DIGITS-1:0] an_o;
  logic                  frame_o;
  modport master (output digit_i, en_i, dp_i, input seg_o, an_o, frame_o);
  modport slave  (input digit_i, en_i, dp_i, output seg_o, an_o, frame_o);
endinterface

// File: rtl/hex_7seg_decoder_anode.sv
// hex_7seg_decoder_anode: hex nibble to active-low {dp,g..a} cathodes
module hex_7seg_decoder_anode (
  input  logic       dp,
  input  logic [3:0] hex_in,
  output logic [7:0] seg_out
);
  localparam logic [6:0] LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  assign seg_out = ~{dp, LUT[hex_in]};
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-seg scanner with blanking gaps and per-frame snapshot
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic            clk,
  input logic            reset,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(cmax(TICK_DIV, BLANK_CYCLES));
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] T_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  scan_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [3:0]            snap_digit_q [NUM_DIGITS-1:0];
  logic [NUM_DIGITS-1:0] snap_en_q, snap_dp_q;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d, dec_seg;
  logic                  frame_q, frame_d;
  logic                  last, take, cur_en, cur_dp;
  logic [3:0]            cur_hex;

  // Outputs are registered from the post-edge idx/snapshot, so the digit
  // being entered is selected straight from the inputs on the snapshot edge.
  always_comb begin
    last    = (state_q == SCAN_BLANK) ? cnt_q == B_LAST : cnt_q == T_LAST;
    take    = last && state_q == SCAN_BLANK;
    state_d = last ? ((state_q == SCAN_BLANK) ? SCAN_ON : SCAN_BLANK) : state_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    idx_d   = take ? ((idx_q == I_LAST) ? '0 : idx_q + 1'b1) : idx_q;
    frame_d = take && idx_q == I_LAST;
    cur_hex = frame_d ? bus.digit_i[idx_d] : snap_digit_q[idx_d];
    cur_en  = frame_d ? bus.en_i[idx_d] : snap_en_q[idx_d];
    cur_dp  = frame_d ? bus.dp_i[idx_d] : snap_dp_q[idx_d];
    an_d    = (state_d == SCAN_ON && cur_en) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    seg_d   = (state_d == SCAN_ON) ? dec_seg : SEG_OFF;
  end

  hex_7seg_decoder_anode u_dec (
    .dp     (cur_dp),
    .hex_in (cur_hex),
    .seg_out(dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCAN_BLANK;
      cnt_q        <= '0;
      idx_q        <= I_LAST;
      snap_digit_q <= '{default: 4'h0};
      snap_en_q    <= '0;
      snap_dp_q    <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      frame_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      if (frame_d) begin
        snap_digit_q <= bus.digit_i;
        snap_en_q    <= bus.en_i;
        snap_dp_q    <= bus.dp_i;
      end
    end
  end

  assign bus.an_o    = an_q;
  assign bus.seg_o   = seg_q;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed frame-by-frame checks of the scan controller
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(3)) bus ();

  seg_scan_ctrl #(.NUM_DIGITS(3), .TICK_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_assert++;
    assert ($countones(~bus.an_o) <= 1)
    else begin
      n_fail++;
      $error("FAIL onehot an_o=%b required at most one low", bus.an_o);
    end
  end

  task automatic cyc(input string tag, input logic [2:0] an_e, input logic [7:0] seg_e,
                     input logic fr_e, input bit chk_seg);
    @(negedge clk);
    n_assert++;
    assert (bus.an_o === an_e)
    else begin
      n_fail++;
      $error("FAIL %s an_o=%b required %b", tag, bus.an_o, an_e);
    end
    n_assert++;
    assert (bus.frame_o === fr_e)
    else begin
      n_fail++;
      $error("FAIL %s frame_o=%b required %b", tag, bus.frame_o, fr_e);
    end
    if (chk_seg) begin
      n_assert++;
      assert (bus.seg_o === seg_e)
      else begin
        n_fail++;
        $error("FAIL %s seg_o=%h required %h", tag, bus.seg_o, seg_e);
      end
    end
  endtask

  // Runs ncyc cycles of a frame starting at digit 0's first lit cycle:
  // each slot is 4 lit cycles then 2 dark cycles.
  task automatic frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [2:0] en, input int ncyc, input bit chg);
    logic [7:0] segs [3];
    segs = '{s0, s1, s2};
    for (int p = 0; p < ncyc; p++) begin
      int s;
      bit lit;
      s   = p / 6;
      lit = (p % 6) < 4;
      if (chg && p == 7) bus.digit_i[0] = 4'hF;
      cyc(tag, lit ? (en[s] ? ~(3'b001 << s) : 3'b111) : 3'b111,
          lit ? segs[s] : 8'hFF, p == 0, !lit || en[s]);
    end
  endtask

  initial begin
    bus.digit_i = '{4'h3, 4'h2, 4'h1};
    bus.en_i    = 3'b111;
    bus.dp_i    = 3'b000;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    cyc("reset", 3'b111, 8'hFF, 1'b0, 1'b1);
    reset = 1'b0;
    cyc("dark2", 3'b111, 8'hFF, 1'b0, 1'b1);
    frame("first_frame", 8'hF9, 8'hA4, 8'hB0, 3'b111, 18, 1'b0);
    frame("scan_123", 8'hF9, 8'hA4, 8'hB0, 3'b111, 18, 1'b0);
    bus.en_i = 3'b101;
    frame("en_101", 8'hF9, 8'hA4, 8'hB0, 3'b101, 18, 1'b0);
    bus.en_i = 3'b111;
    frame("midframe_chg", 8'hF9, 8'hA4, 8'hB0, 3'b111, 18, 1'b1);
    frame("chg_visible", 8'h8E, 8'hA4, 8'hB0, 3'b111, 18, 1'b0);
    bus.dp_i = 3'b100;
    frame("dp_100", 8'h8E, 8'hA4, 8'h30, 3'b111, 18, 1'b0);
    frame("pre_reset", 8'h8E, 8'hA4, 8'h30, 3'b111, 8, 1'b0);
    reset = 1'b1;
    cyc("reset_mid", 3'b111, 8'hFF, 1'b0, 1'b1);
    reset = 1'b0;
    cyc("rst_dark2", 3'b111, 8'hFF, 1'b0, 1'b1);
    frame("after_reset", 8'h8E, 8'hA4, 8'h30, 3'b111, 18, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
